pe_share_arbiter: RTL
=====================

Name: pe_share_arbiter

Overview:
- Shares one priority_encoder instance between NUM_CLIENTS requesters using round-robin arbitration.
- Per transaction: latches the granted client's data vector, drives the encoder start/ready/done handshake, captures result and zero flag, and returns them to the owning client with a one-cycle response pulse.
- A watchdog terminates transactions that hang.
- Sits between the client blocks and the single encoder datapath.

Parameters:
- NUM_CLIENTS, 4, number of requesters (≥2).
- DATA_LEN, 20, encoder input width.
- RESULT_LEN, $clog2(DATA_LEN), encoder result width.
- IDX_W, $clog2(NUM_CLIENTS), client index width.
- TIMEOUT_CYCLES, 255, maximum WAIT_DONE cycles before abort (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_CLIENTS  per-client request level; data held stable until gnt seen.
- req_data  in  NUM_CLIENTS*DATA_LEN  packed client vectors; client i at [i*DATA_LEN +: DATA_LEN].
- gnt  out  NUM_CLIENTS  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  NUM_CLIENTS  one-hot, one-cycle pulse to owning client.
- rsp_result  out  RESULT_LEN  captured encoder result.
- rsp_zero_f  out  1  captured zero flag.
- rsp_timeout  out  1  transaction aborted by watchdog.
- rsp_owner  out  IDX_W  index of the client that owns the current rsp.
- busy  out  1  state != IDLE.
- pe_start  out  1  encoder start pulse.
- pe_data  out  DATA_LEN  encoder input.
- pe_ready  in  1  encoder can accept start.
- pe_done  in  1  encoder done (level, may last >1 cycle).
- pe_result  in  RESULT_LEN  encoder result.
- pe_zero_f  in  1  encoder zero flag.

Behaviour:
- All outputs are registered. Reset (rst=0, asynchronous) forces: all outputs 0, state IDLE, RR pointer 0, watchdog counter 0. Reset mid-transaction aborts it silently; no rsp_valid is issued.
- States: IDLE, WAIT_DONE, RELEASE.
- IDLE:
  - A grant occurs when |req and pe_ready=1 and pe_done=0.
  - Winner = first asserted req scanning upward from the RR pointer, wrapping NUM_CLIENTS-1→0.
  - At the grant edge: pe_data←winner's data; owner←winner; gnt[winner]←1; pe_start←1; RR pointer←(winner+1) mod NUM_CLIENTS; state←WAIT_DONE.
  - gnt and pe_start are high together for exactly one cycle, one cycle after the grant condition is sampled.
- WAIT_DONE:
  - gnt and pe_start return to 0. req is ignored, so a client still holding req is never double-granted.
  - Watchdog increments every cycle from 0.
  - First edge with pe_done=1: rsp_result←pe_result; rsp_zero_f←pe_zero_f; rsp_timeout←0; rsp_owner←owner; rsp_valid[owner]←1; state←RELEASE.
  - If the watchdog reaches TIMEOUT_CYCLES with pe_done still 0: rsp_result←0; rsp_zero_f←0; rsp_timeout←1; rsp_valid[owner]←1; state←RELEASE.
  - pe_done takes priority over timeout on the same edge.
- RELEASE:
  - rsp_valid returns to 0 after one cycle.
  - Transition to IDLE on the first edge with pe_done=0. This holds off a new start until the encoder's done level drops.
- pe_data stays stable from pe_start until the next grant.
- rsp_result, rsp_zero_f, rsp_timeout and rsp_owner hold their values until the next response.
- Latency, encoder done after D cycles of pe_start: req sampled → gnt/pe_start +1 cycle → rsp_valid 1 cycle after pe_done is first sampled high.
- Minimum grant-to-grant spacing: 3 cycles.
- A client that receives rsp_valid and re-asserts req in the same cycle is treated normally on the next IDLE evaluation.
- With a single requester continuously asserting, it is granted back-to-back (no starvation of others: the RR pointer has already moved past it).
- pe_ready=0 in IDLE stalls the grant; req is not latched and gnt is not asserted.

Test Plan:
- Bench uses an encoder model returning the index of the highest set bit, zero_f for all-zero input, done high for 2 cycles after a 3-cycle latency, ready low while busy.
- Single request: client 1 req_data=20'h0354D → gnt[1] pulse with pe_start, pe_data=20'h0354D, then rsp_valid[1] with rsp_result=13, rsp_zero_f=0, rsp_timeout=0, rsp_owner=1.
- Zero input: client 0 data=0 → rsp_result=0, rsp_zero_f=1; client 2 data=20'h005C3 → rsp_result=10; client 3 data=20'h805C3 → rsp_result=19.
- Round-robin: all four clients hold req after reset → grant order 0,1,2,3,0. Each rsp_valid goes only to its owner and no client is granted twice in the same transaction.
- Handshake stall: hold pe_ready=0 for 10 cycles with req[2]=1 → no gnt, busy=0. On pe_ready=1 → gnt[2] on the next cycle.
- Timeout (TIMEOUT_CYCLES=8): encoder model never raises done → rsp_valid[owner] exactly 8 cycles after the pe_start cycle, rsp_timeout=1, rsp_result=0. Arbiter then returns to IDLE.
- Reset mid-transaction: drive rst=0 asynchronously during WAIT_DONE → all outputs 0 immediately, no rsp_valid after release. The next grant starts from client 0.

Source files
------------

// File: rtl/pe_share_arbiter.sv
// Round-robin arbiter that time-shares one priority encoder between several clients.
// It runs the encoder start/ready/done handshake, returns the result to the owner and aborts hung jobs.
module pe_share_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int DATA_LEN       = 20,
  parameter int RESULT_LEN     = $clog2(DATA_LEN),
  parameter int IDX_W          = $clog2(NUM_CLIENTS),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS*DATA_LEN-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]          gnt,
  output logic [NUM_CLIENTS-1:0]          rsp_valid,
  output logic [RESULT_LEN-1:0]           rsp_result,
  output logic                            rsp_zero_f,
  output logic                            rsp_timeout,
  output logic [IDX_W-1:0]                rsp_owner,
  output logic                            busy,
  output logic                            pe_start,
  output logic [DATA_LEN-1:0]             pe_data,
  input  logic                            pe_ready,
  input  logic                            pe_done,
  input  logic [RESULT_LEN-1:0]           pe_result,
  input  logic                            pe_zero_f
);

  // state     | meaning
  // S_IDLE    | waiting for a request while the encoder is ready and not done
  // S_WAIT_DONE | job issued, waiting for done or watchdog expiry
  // S_RELEASE | response issued, waiting for the encoder done level to drop
  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_RELEASE} state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]   NUM_C   = (IDX_W+1)'(NUM_CLIENTS);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic [NUM_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [NUM_CLIENTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RESULT_LEN-1:0]    rsp_result_q, rsp_result_d;
  logic                     rsp_zero_f_q, rsp_zero_f_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic [IDX_W-1:0]         rsp_owner_q, rsp_owner_d;
  logic                     busy_q, busy_d;
  logic                     pe_start_q, pe_start_d;
  logic [DATA_LEN-1:0]      pe_data_q, pe_data_d;

  logic [DATA_LEN-1:0]      client_data [NUM_CLIENTS];
  logic                     win_found;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W:0]           scan;
  logic [IDX_W:0]           ptr_nxt;

  always_comb begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      client_data[k] = req_data[k*DATA_LEN +: DATA_LEN];
    end
  end

  // Scan upward from the pointer with wrap; the first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan >= NUM_C) scan = scan - NUM_C;
      if (!win_found && req[scan[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDX_W-1:0];
      end
    end
    ptr_nxt = {1'b0, win_idx} + (IDX_W+1)'(1);
    if (ptr_nxt == NUM_C) ptr_nxt = '0;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    wd_d          = wd_q;
    gnt_d         = '0;
    pe_start_d    = 1'b0;
    rsp_valid_d   = '0;
    rsp_result_d  = rsp_result_q;
    rsp_zero_f_d  = rsp_zero_f_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_owner_d   = rsp_owner_q;
    pe_data_d     = pe_data_q;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (win_found && pe_ready && !pe_done) begin
          pe_data_d      = client_data[win_idx];
          owner_d        = win_idx;
          gnt_d[win_idx] = 1'b1;
          pe_start_d     = 1'b1;
          ptr_d          = ptr_nxt[IDX_W-1:0];
          state_d        = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WD_W'(1);
        if (pe_done) begin
          rsp_result_d         = pe_result;
          rsp_zero_f_d         = pe_zero_f;
          rsp_timeout_d        = 1'b0;
          rsp_owner_d          = owner_q;
          rsp_valid_d[owner_q] = 1'b1;
          wd_d                 = '0;
          state_d              = S_RELEASE;
        end else if (wd_q == WD_LAST) begin
          rsp_result_d         = '0;
          rsp_zero_f_d         = 1'b0;
          rsp_timeout_d        = 1'b1;
          rsp_owner_d          = owner_q;
          rsp_valid_d[owner_q] = 1'b1;
          wd_d                 = '0;
          state_d              = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Holding here until done drops keeps a stale done level from closing the next job.
        if (!pe_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      wd_q          <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_zero_f_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_owner_q   <= '0;
      busy_q        <= 1'b0;
      pe_start_q    <= 1'b0;
      pe_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      wd_q          <= wd_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_f_q  <= rsp_zero_f_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_owner_q   <= rsp_owner_d;
      busy_q        <= busy_d;
      pe_start_q    <= pe_start_d;
      pe_data_q     <= pe_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero_f  = rsp_zero_f_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_owner   = rsp_owner_q;
  assign busy        = busy_q;
  assign pe_start    = pe_start_q;
  assign pe_data     = pe_data_q;

endmodule
